adc_packet_sequencer: RTL and testbench

- Controller between the UDP command parser and the UDP transmit FIFO.
- A one-cycle `start` pulse (the parser's send-ADC-data strobe) triggers one packet: one header word, then SAMPLES_PER_PKT 16-bit ADC samples packed two per 32-bit word, then a one-cycle `pkt_send` request to the UDP TX engine.
- The ADC stream cannot be stalled. Sample pairs that arrive while the FIFO is full are dropped and flagged.

---
 rtl/adc_packet_sequencer.sv | 107 ++++++++++
 tb/tb_adc_packet_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/adc_packet_sequencer.sv
// adc_packet_sequencer: frames ADC sample pairs into header+payload packets for the UDP TX FIFO
module adc_packet_sequencer #(
    parameter int          SAMPLES_PER_PKT = 512,
    parameter logic [15:0] HDR_MAGIC       = 16'hADC0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_adc_valid,
    input  logic [15:0] i_adc_data,
    input  logic        i_fifo_full,
    output logic        o_fifo_wr_en,
    output logic [31:0] o_fifo_din,
    output logic        o_pkt_send,
    output logic [15:0] o_pkt_len,
    output logic [15:0] o_seq_num,
    output logic        o_busy,
    output logic        o_overflow
);
    typedef enum logic [3:0] {
        S_IDLE    = 4'b0001,
        S_HEADER  = 4'b0010,
        S_CAPTURE = 4'b0100,
        S_SEND    = 4'b1000
    } state_t;

    localparam logic [15:0] LAST_PAIR = 16'(SAMPLES_PER_PKT / 2 - 1);
    localparam logic [15:0] PKT_LEN   = 16'(4 * (1 + SAMPLES_PER_PKT / 2));

    state_t      r_state;
    logic        r_wr_en;
    logic [31:0] r_din;
    logic        r_pkt_send;
    logic [15:0] r_pkt_len;
    logic [15:0] r_seq_num;
    logic        r_busy;
    logic        r_overflow;
    logic [15:0] r_pair_cnt;
    logic        r_phase;
    logic [15:0] r_held;

    assign o_fifo_wr_en = r_wr_en;
    assign o_fifo_din   = r_din;
    assign o_pkt_send   = r_pkt_send;
    assign o_pkt_len    = r_pkt_len;
    assign o_seq_num    = r_seq_num;
    assign o_busy       = r_busy;
    assign o_overflow   = r_overflow;

    // Packet FSM: header write, pair packing with drop-on-full, then a single send request
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_wr_en    <= 1'b0;
            r_din      <= '0;
            r_pkt_send <= 1'b0;
            r_pkt_len  <= '0;
            r_seq_num  <= '0;
            r_busy     <= 1'b0;
            r_overflow <= 1'b0;
            r_pair_cnt <= '0;
            r_phase    <= 1'b0;
            r_held     <= '0;
        end else begin
            r_wr_en    <= 1'b0;
            r_pkt_send <= 1'b0;
            case (r_state)
                S_IDLE: if (i_start) begin
                    r_state    <= S_HEADER;
                    r_busy     <= 1'b1;
                    r_overflow <= 1'b0;
                    r_pair_cnt <= '0;
                    r_phase    <= 1'b0;
                end
                S_HEADER: if (!i_fifo_full) begin
                    r_wr_en <= 1'b1;
                    r_din   <= {HDR_MAGIC, r_seq_num};
                    r_state <= S_CAPTURE;
                end
                S_CAPTURE: if (i_adc_valid) begin
                    r_phase <= ~r_phase;
                    if (!r_phase) begin
                        r_held <= i_adc_data;
                    end else if (!i_fifo_full) begin
                        r_wr_en    <= 1'b1;
                        r_din      <= {i_adc_data, r_held};
                        r_pair_cnt <= r_pair_cnt + 16'd1;
                        if (r_pair_cnt == LAST_PAIR) r_state <= S_SEND;
                    end else begin
                        r_overflow <= 1'b1;
                    end
                end
                S_SEND: begin
                    r_pkt_send <= 1'b1;
                    r_pkt_len  <= PKT_LEN;
                    r_seq_num  <= r_seq_num + 16'd1;
                    r_busy     <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_adc_packet_sequencer.sv
// tb_adc_packet_sequencer: directed scenarios for the ADC packet sequencer with SAMPLES_PER_PKT=4
module tb_adc_packet_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        adc_valid = 1'b0;
    logic [15:0] adc_data = '0;
    logic        fifo_full = 1'b0;
    logic        fifo_wr_en;
    logic [31:0] fifo_din;
    logic        pkt_send;
    logic [15:0] pkt_len;
    logic [15:0] seq_num;
    logic        busy;
    logic        overflow;

    int          vecs = 0;
    int          errs = 0;
    int          sends = 0;
    int          s0;
    logic [15:0] last_len;
    logic [31:0] wq[$];
    logic [31:0] got;

    adc_packet_sequencer #(.SAMPLES_PER_PKT(4), .HDR_MAGIC(16'hADC0)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_adc_valid(adc_valid),
        .i_adc_data(adc_data), .i_fifo_full(fifo_full), .o_fifo_wr_en(fifo_wr_en),
        .o_fifo_din(fifo_din), .o_pkt_send(pkt_send), .o_pkt_len(pkt_len),
        .o_seq_num(seq_num), .o_busy(busy), .o_overflow(overflow)
    );

    always #5 clk = ~clk;

    // Record every FIFO write and send request shortly after each active edge
    always @(posedge clk) begin
        #1;
        if (fifo_wr_en) wq.push_back(fifo_din);
        if (pkt_send) begin
            sends++;
            last_len = pkt_len;
        end
    end

    task automatic feed(input logic [15:0] base, input int n, input logic [7:0] full_mask);
        for (int i = 0; i < n; i++) begin
            adc_valid = 1'b1;
            adc_data  = base + 16'(i);
            fifo_full = full_mask[i];
            @(negedge clk);
        end
        adc_valid = 1'b0;
        fifo_full = 1'b0;
    endtask

    task automatic wait_send(input int base_cnt);
        for (int i = 0; i < 20 && sends == base_cnt; i++) @(negedge clk);
        vecs++;
        if (sends == base_cnt) begin
            errs++;
            $display("FAIL pkt_send_timeout: got no pulse, required 1 pulse within 20 cycles");
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        vecs++; if (fifo_wr_en !== 1'b0) begin errs++; $display("FAIL rst_wr_en: got %b required 0", fifo_wr_en); end
        vecs++; if (fifo_din !== 32'h0) begin errs++; $display("FAIL rst_din: got %h required 00000000", fifo_din); end
        vecs++; if (pkt_send !== 1'b0) begin errs++; $display("FAIL rst_pkt_send: got %b required 0", pkt_send); end
        vecs++; if (seq_num !== 16'h0) begin errs++; $display("FAIL rst_seq: got %h required 0000", seq_num); end
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL rst_busy: got %b required 0", busy); end
        vecs++; if (overflow !== 1'b0) begin errs++; $display("FAIL rst_overflow: got %b required 0", overflow); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [31:0] exp_w[3] = '{32'hADC00000, 32'h00020001, 32'h00040003};
        wq.delete(); s0 = sends;
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL basic_busy_lat: got %b required 1", busy); end
        vecs++; if (fifo_wr_en !== 1'b0) begin errs++; $display("FAIL basic_early_wr: got %b required 0", fifo_wr_en); end
        @(negedge clk);
        vecs++; if (fifo_wr_en !== 1'b1 || fifo_din !== 32'hADC00000) begin errs++; $display("FAIL basic_hdr_lat: got wr=%b din=%h required wr=1 din=adc00000", fifo_wr_en, fifo_din); end
        feed(16'h0001, 4, 8'h00);
        wait_send(s0);
        vecs++; if (pkt_send !== 1'b1 || pkt_len !== 16'd12) begin errs++; $display("FAIL basic_send: got send=%b len=%0d required send=1 len=12", pkt_send, pkt_len); end
        vecs++; if (seq_num !== 16'd1 || busy !== 1'b0) begin errs++; $display("FAIL basic_seq_busy: got seq=%h busy=%b required seq=0001 busy=0", seq_num, busy); end
        @(negedge clk);
        vecs++; if (pkt_send !== 1'b0) begin errs++; $display("FAIL basic_send_width: got %b required 0", pkt_send); end
        vecs++; if (wq.size() != 3) begin errs++; $display("FAIL basic_wcount: got %0d required 3", wq.size()); end
        for (int i = 0; i < 3; i++) begin
            got = (i < wq.size()) ? wq[i] : 32'hxxxxxxxx;
            vecs++; if (got !== exp_w[i]) begin errs++; $display("FAIL basic_word%0d: got %h required %h", i, got, exp_w[i]); end
        end
    endtask

    task automatic test_header_backpressure();
        logic [31:0] exp_w[3] = '{32'hADC00001, 32'h00120011, 32'h00140013};
        wq.delete(); s0 = sends;
        start = 1'b1; fifo_full = 1'b1; adc_valid = 1'b1; adc_data = 16'hBAD0;
        repeat (5) begin
            @(negedge clk); start = 1'b0;
        end
        fifo_full = 1'b0; adc_valid = 1'b0;
        vecs++; if (wq.size() != 0 || busy !== 1'b1) begin errs++; $display("FAIL bp_held: got writes=%0d busy=%b required writes=0 busy=1", wq.size(), busy); end
        @(negedge clk);
        vecs++; if (fifo_wr_en !== 1'b1 || fifo_din !== 32'hADC00001) begin errs++; $display("FAIL bp_hdr: got wr=%b din=%h required wr=1 din=adc00001", fifo_wr_en, fifo_din); end
        feed(16'h0011, 4, 8'h00);
        wait_send(s0);
        vecs++; if (last_len !== 16'd12 || seq_num !== 16'd2) begin errs++; $display("FAIL bp_send: got len=%0d seq=%h required len=12 seq=0002", last_len, seq_num); end
        vecs++; if (wq.size() != 3) begin errs++; $display("FAIL bp_wcount: got %0d required 3", wq.size()); end
        for (int i = 0; i < 3; i++) begin
            got = (i < wq.size()) ? wq[i] : 32'hxxxxxxxx;
            vecs++; if (got !== exp_w[i]) begin errs++; $display("FAIL bp_word%0d: got %h required %h", i, got, exp_w[i]); end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] exp_w[3] = '{32'hADC00002, 32'h00040003, 32'h00060005};
        wq.delete(); s0 = sends;
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        feed(16'h0001, 6, 8'b0000_0010);
        wait_send(s0);
        vecs++; if (overflow !== 1'b1) begin errs++; $display("FAIL ovf_flag: got %b required 1", overflow); end
        vecs++; if (last_len !== 16'd12) begin errs++; $display("FAIL ovf_len: got %0d required 12", last_len); end
        vecs++; if (wq.size() != 3) begin errs++; $display("FAIL ovf_wcount: got %0d required 3", wq.size()); end
        for (int i = 0; i < 3; i++) begin
            got = (i < wq.size()) ? wq[i] : 32'hxxxxxxxx;
            vecs++; if (got !== exp_w[i]) begin errs++; $display("FAIL ovf_word%0d: got %h required %h", i, got, exp_w[i]); end
        end
        repeat (3) @(negedge clk);
        vecs++; if (overflow !== 1'b1) begin errs++; $display("FAIL ovf_sticky: got %b required 1", overflow); end
    endtask

    task automatic test_ignored_starts();
        s0 = sends;
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        vecs++; if (overflow !== 1'b0) begin errs++; $display("FAIL ign_ovf_clear: got %b required 0", overflow); end
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            adc_valid = 1'b1;
            adc_data  = 16'(i + 1);
            start     = (i == 1);
            @(negedge clk);
        end
        adc_valid = 1'b0;
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        vecs++; if (sends - s0 != 1) begin errs++; $display("FAIL ign_sends: got %0d required 1", sends - s0); end
        vecs++; if (seq_num !== 16'd4 || busy !== 1'b0) begin errs++; $display("FAIL ign_seq: got seq=%h busy=%b required seq=0004 busy=0", seq_num, busy); end
    endtask

    task automatic test_reset_mid_packet();
        wq.delete();
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        feed(16'h0001, 3, 8'h00);
        vecs++; if (wq.size() != 2) begin errs++; $display("FAIL mid_pre_writes: got %0d required 2", wq.size()); end
        s0 = sends;
        rst_n = 1'b0;
        #1;
        vecs++; if (fifo_wr_en !== 1'b0 || fifo_din !== 32'h0 || pkt_send !== 1'b0 || pkt_len !== 16'h0) begin errs++; $display("FAIL mid_rst_data: got wr=%b din=%h send=%b len=%h required all 0", fifo_wr_en, fifo_din, pkt_send, pkt_len); end
        vecs++; if (seq_num !== 16'h0 || busy !== 1'b0 || overflow !== 1'b0) begin errs++; $display("FAIL mid_rst_ctrl: got seq=%h busy=%b ovf=%b required all 0", seq_num, busy, overflow); end
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);
        vecs++; if (sends != s0) begin errs++; $display("FAIL mid_no_send: got %0d pulses required 0", sends - s0); end
        wq.delete(); s0 = sends;
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        vecs++; if (fifo_wr_en !== 1'b1 || fifo_din !== 32'hADC00000) begin errs++; $display("FAIL mid_new_hdr: got wr=%b din=%h required wr=1 din=adc00000", fifo_wr_en, fifo_din); end
        feed(16'h0001, 4, 8'h00);
        wait_send(s0);
        vecs++; if (seq_num !== 16'd1) begin errs++; $display("FAIL mid_seq: got %h required 0001", seq_num); end
    endtask

    task automatic test_seq_wrap();
        force dut.r_seq_num = 16'hFFFF;
        @(negedge clk);
        release dut.r_seq_num;
        @(negedge clk);
        vecs++; if (seq_num !== 16'hFFFF) begin errs++; $display("FAIL wrap_preset: got %h required ffff", seq_num); end
        wq.delete(); s0 = sends;
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        feed(16'h0001, 4, 8'h00);
        wait_send(s0);
        got = (wq.size() > 0) ? wq[0] : 32'hxxxxxxxx;
        vecs++; if (got !== 32'hADC0FFFF) begin errs++; $display("FAIL wrap_hdr_ffff: got %h required adc0ffff", got); end
        vecs++; if (seq_num !== 16'h0000) begin errs++; $display("FAIL wrap_seq: got %h required 0000", seq_num); end
        @(negedge clk);
        wq.delete(); s0 = sends;
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        vecs++; if (fifo_wr_en !== 1'b1 || fifo_din !== 32'hADC00000) begin errs++; $display("FAIL wrap_hdr_0000: got wr=%b din=%h required wr=1 din=adc00000", fifo_wr_en, fifo_din); end
        feed(16'h0001, 4, 8'h00);
        wait_send(s0);
        vecs++; if (seq_num !== 16'h0001) begin errs++; $display("FAIL wrap_seq_next: got %h required 0001", seq_num); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_header_backpressure();
        test_overflow();
        test_ignored_starts();
        test_reset_mid_packet();
        test_seq_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
